memoria_datos_ext: RTL

//  MIPS data memory, MEM stage, successor of the word-only data memory.

---
 rtl/memoria_datos_ext_if.sv | 45 ++++
 rtl/memoria_datos_ext.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/memoria_datos_ext_if.sv
// Bus between the MEM-stage datapath / debug unit and the data memory.
// Request protocol: a load or store is a single-cycle request. The master
// holds i_MemRead and/or i_MemWrite high together with address, size, sign
// mode and store data for exactly the cycle it wants serviced. There is no
// stall or backpressure. o_Ready is the only ready indication: requests made
// while o_Ready=0 (post-reset clear in progress) are dropped without any
// effect or error flag. Load data and error flags appear one cycle after the
// request.
interface memoria_datos_ext_if #(
    parameter int NBITS    = 32,
    parameter int IDX_BITS = 8
);
    // Main load/store port
    logic [NBITS-1:0]    i_ALUDireccion;
    logic [NBITS-1:0]    i_DatoRegistro;
    logic                i_MemWrite;
    logic                i_MemRead;
    logic [1:0]          i_Size;
    logic                i_Unsigned;
    logic [NBITS-1:0]    o_DatoLeido;
    logic                o_Ready;
    logic                o_ErrAlign;
    logic                o_ErrRange;

    // Debug dump port
    logic [IDX_BITS-1:0] i_DebugAddr;
    logic [NBITS-1:0]    o_DebugDato;

    // Controller state, exposed for observation (0 = clearing, 1 = running)
    logic [0:0]          o_Estado;

    modport slave (
        input  i_ALUDireccion, i_DatoRegistro, i_MemWrite, i_MemRead,
        input  i_Size, i_Unsigned, i_DebugAddr,
        output o_DatoLeido, o_Ready, o_ErrAlign, o_ErrRange, o_DebugDato,
        output o_Estado
    );

    modport master (
        output i_ALUDireccion, i_DatoRegistro, i_MemWrite, i_MemRead,
        output i_Size, i_Unsigned, i_DebugAddr,
        input  o_DatoLeido, o_Ready, o_ErrAlign, o_ErrRange, o_DebugDato,
        input  o_Estado
    );
endinterface

// File: rtl/memoria_datos_ext.sv
// MIPS MEM-stage data memory: byte-addressed, little-endian, with byte/half/
// word loads and stores, sign or zero extension, alignment and range error
// pulses, a self-clear after reset and a registered debug read port.
module memoria_datos_ext #(
    parameter int NBITS       = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic               i_clk,
    input  logic               i_reset,
    memoria_datos_ext_if.slave bus
);
    localparam int IDX_BITS = $clog2(DEPTH_WORDS);
    localparam int LANES    = NBITS / 8;

    // Controller states
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Access size encodings; 2'b10 and 2'b11 both mean word
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    // Storage and registered state
    logic [NBITS-1:0]    mem_q [DEPTH_WORDS];
    logic [0:0]          state_q, state_d;
    logic [IDX_BITS-1:0] clr_cnt_q, clr_cnt_d;
    logic [NBITS-1:0]    dato_q, dato_d;
    logic [NBITS-1:0]    debug_q;
    logic                err_align_q, err_align_d;
    logic                err_range_q, err_range_d;

    // Request decode
    logic [IDX_BITS-1:0] word_idx;
    logic [1:0]          lane;
    logic                req;
    logic                running;
    logic                out_of_range;
    logic                misaligned;
    logic                access_ok;

    // Store lane steering
    logic [LANES-1:0]    st_be;
    logic [NBITS-1:0]    st_data;

    // Single write port shared by the clear sweep and stores
    logic                mem_we;
    logic [IDX_BITS-1:0] mem_widx;
    logic [LANES-1:0]    mem_be;
    logic [NBITS-1:0]    mem_wdata;

    // Load path
    logic [NBITS-1:0]    rd_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [NBITS-1:0]    load_val;

    assign word_idx     = bus.i_ALUDireccion[IDX_BITS+1:2];
    assign lane         = bus.i_ALUDireccion[1:0];
    assign req          = bus.i_MemRead | bus.i_MemWrite;
    assign running      = (state_q == ST_RUN);
    // Any address bit above the word index set means past the last word
    assign out_of_range = |bus.i_ALUDireccion[NBITS-1:IDX_BITS+2];
    // Range has priority, so a request is good only if both checks pass
    assign access_ok    = !out_of_range && !misaligned;

    // Alignment check by access size; bytes can never be misaligned
    always_comb begin
        misaligned = 1'b0;
        case (bus.i_Size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lane[0];
            default: misaligned = (lane != 2'b00);
        endcase
    end

    // Byte enables and replicated store data so each lane sees its slice
    always_comb begin
        st_be   = '0;
        st_data = '0;
        case (bus.i_Size)
            SZ_BYTE: begin
                st_be   = LANES'(4'b0001 << lane);
                st_data = {4{bus.i_DatoRegistro[7:0]}};
            end
            SZ_HALF: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.i_DatoRegistro[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = bus.i_DatoRegistro;
            end
        endcase
    end

    // Write port mux: the clear sweep owns the port until RUN
    always_comb begin
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_widx  = clr_cnt_q;
            mem_be    = '1;
            mem_wdata = '0;
        end else begin
            mem_we    = bus.i_MemWrite && access_ok;
            mem_widx  = word_idx;
            mem_be    = st_be;
            mem_wdata = st_data;
        end
    end

    // Byte-lane write into the array; no reset, the clear sweep initialises it
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Load extraction: pick lane, then sign- or zero-extend
    assign rd_word = mem_q[word_idx];

    always_comb begin
        rd_byte  = rd_word[{lane, 3'b000} +: 8];
        rd_half  = rd_word[{lane[1], 4'b0000} +: 16];
        load_val = rd_word;
        case (bus.i_Size)
            SZ_BYTE: load_val = {{24{~bus.i_Unsigned & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_val = {{16{~bus.i_Unsigned & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Controller: sweep every word once, then stay in RUN until reset
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            if (clr_cnt_q == IDX_BITS'(DEPTH_WORDS - 1)) begin
                state_d = ST_RUN;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end
    end

    // Next load result and error pulses; nothing is serviced while clearing
    always_comb begin
        dato_d      = dato_q;
        err_align_d = 1'b0;
        err_range_d = 1'b0;
        if (!running) begin
            dato_d = '0;
        end else begin
            err_range_d = req && out_of_range;
            err_align_d = req && !out_of_range && misaligned;
            if (bus.i_MemRead) begin
                dato_d = access_ok ? load_val : '0;
            end
        end
    end

    // Registered state and outputs; debug port reads every cycle
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            dato_q      <= '0;
            debug_q     <= '0;
            err_align_q <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            dato_q      <= dato_d;
            debug_q     <= mem_q[bus.i_DebugAddr];
            err_align_q <= err_align_d;
            err_range_q <= err_range_d;
        end
    end

    assign bus.o_DatoLeido = dato_q;
    assign bus.o_DebugDato = debug_q;
    assign bus.o_Ready     = running;
    assign bus.o_ErrAlign  = err_align_q;
    assign bus.o_ErrRange  = err_range_q;
    assign bus.o_Estado    = state_q;

endmodule
